// File: rtl/stall_flush_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stall_flush_ctrl                                            |
// | Description : Pipeline hazard controller. Merges per-stage stall requests |
// |               and a multi-cycle-op counter into a prefix stall mask and   |
// |               issues prefix flush masks, deferring a flush while the      |
// |               requesting stage is itself held.                            |
// | Option      : PERF_CNT_EN adds a saturating stall-cycle counter with      |
// |               perf_clr / perf_stall_cnt ports.                            |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module stall_flush_ctrl #(
    parameter int NSTAGE   = 6,
    parameter int SIDX_W   = 3,
    parameter int MC_STAGE = 3,
    parameter int CNT_W    = 6
`ifdef PERF_CNT_EN
    ,
    parameter int PERF_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              stall_release,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_cycles,
    input  logic              mc_abort,
    input  logic              flush_req,
    input  logic [SIDX_W-1:0] flush_stage,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              mc_busy,
    output logic              mc_done
`ifdef PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [0:0]        c_S_IDLE = 1'b0;
    localparam logic [0:0]        c_S_BUSY = 1'b1;
    localparam logic [SIDX_W-1:0] c_TOP    = SIDX_W'(NSTAGE - 1);
    localparam logic [SIDX_W-1:0] c_MC_IDX = SIDX_W'(MC_STAGE);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_flush_pend;
    logic [SIDX_W-1:0] r_pend_stage;

    logic              w_busy;
    logic              w_start_long;
    logic              w_mc_stall;
    logic              w_mc_kill;
    logic [NSTAGE-1:0] w_eff;
    logic [NSTAGE-1:0] w_stall_pre;
    logic [SIDX_W-1:0] w_req_stage;
    logic [SIDX_W-1:0] w_cand;
    logic              w_cand_valid;
    logic              w_honour;
    logic [NSTAGE-1:0] w_flush_mask;

    assign w_busy       = (r_state == c_S_BUSY);
    assign w_start_long = mc_start && (mc_cycles >= CNT_W'(2));

    // Multi-cycle unit holds its stage on the start cycle and every BUSY
    // cycle except the final one; an abort releases the hold immediately.
    assign w_mc_stall = (!w_busy && w_start_long) ||
                        (w_busy && (r_cnt != '0) && !mc_abort);

    assign w_eff = stall_req | (NSTAGE'(w_mc_stall) << MC_STAGE);

    // Prefix hold: every stage at or below the oldest requester is held.
    always_comb begin
        logic w_acc;
        w_acc       = 1'b0;
        w_stall_pre = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            w_acc          = w_acc | w_eff[i];
            w_stall_pre[i] = w_acc & ~stall_release;
        end
    end

    assign w_req_stage  = (flush_stage > c_TOP) ? c_TOP : flush_stage;
    assign w_cand_valid = flush_req | r_flush_pend;

    // Merge a new flush with a pending one: the older stage squashes more.
    always_comb begin
        w_cand = r_pend_stage;
        if (flush_req) begin
            if (r_flush_pend && (r_pend_stage > w_req_stage))
                w_cand = r_pend_stage;
            else
                w_cand = w_req_stage;
        end
    end

    // The MC hold bit sits below any stage whose flush would cover MC_STAGE,
    // so using the pre-kill hold here does not change the honour decision.
    assign w_honour = w_cand_valid && ((w_cand == c_TOP) || !w_stall_pre[w_cand]);

    // Squash mask covers all stages younger than the flushing stage.
    always_comb begin
        w_flush_mask = '0;
        for (int i = 0; i < NSTAGE; i++)
            w_flush_mask[i] = (SIDX_W'(i) < w_cand);
    end

    assign w_mc_kill = w_busy && (mc_abort || (w_honour && (w_cand > c_MC_IDX)));

    // Flushed stages take a bubble, so their hold is dropped; this also
    // removes the MC hold when a flush kills the running op.
    assign flush   = (rst || !w_honour) ? '0 : w_flush_mask;
    assign stall   = rst ? '0 : (w_stall_pre & ~flush);
    assign mc_busy = w_busy;
    assign mc_done = !rst && ((!w_busy && mc_start && !w_start_long) ||
                              (w_busy && (r_cnt == '0) && !w_mc_kill));

    // Multi-cycle FSM: load N-2 on entry, count down, leave on zero or kill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else if (!w_busy) begin
            if (w_start_long) begin
                r_state <= c_S_BUSY;
                r_cnt   <= mc_cycles - CNT_W'(2);
            end
        end else if (w_mc_kill || (r_cnt == '0)) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Remember a blocked flush until its stage is able to advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
            r_pend_stage <= '0;
        end else if (w_cand_valid) begin
            if (w_honour) begin
                r_flush_pend <= 1'b0;
            end else begin
                r_flush_pend <= 1'b1;
                r_pend_stage <= w_cand;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [PERF_W-1:0] r_perf;

    // Saturating count of cycles with any stage held; clear wins.
    always_ff @(posedge clk) begin
        if (rst || perf_clr)
            r_perf <= '0;
        else if ((stall != '0) && (r_perf != '1))
            r_perf <= r_perf + PERF_W'(1);
    end

    assign perf_stall_cnt = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stall_flush_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stall_flush_ctrl                                         |
// | Description : Self-checking bench for stall_flush_ctrl (NSTAGE=6,         |
// |               MC_STAGE=3). Behavioural model compared every cycle, plus   |
// |               hand-computed literal expectations. Honours PERF_CNT_EN.    |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_stall_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall_req;
    logic       stall_release;
    logic       mc_start;
    logic [5:0] mc_cycles;
    logic       mc_abort;
    logic       flush_req;
    logic [2:0] flush_stage;
    logic [5:0] stall;
    logic [5:0] flush;
    logic       mc_busy;
    logic       mc_done;
`ifdef PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    stall_flush_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .stall_release (stall_release),
        .mc_start      (mc_start),
        .mc_cycles     (mc_cycles),
        .mc_abort      (mc_abort),
        .flush_req     (flush_req),
        .flush_stage   (flush_stage),
        .stall         (stall),
        .flush         (flush),
        .mc_busy       (mc_busy),
        .mc_done       (mc_done)
`ifdef PERF_CNT_EN
        ,
        .perf_clr      (perf_clr),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: remaining BUSY cycles of the op, pending flush, perf count.
    int          m_rem    = 0;
    bit          m_pend   = 1'b0;
    int          m_pstage = 0;
    logic [31:0] m_perf   = '0;

    // Evaluate the rules on the current inputs, compare, then advance state.
    always @(negedge clk) begin
        bit         busy, hold, done, have, honour, kill;
        logic [5:0] effv, est, efl;
        int         h, s;
        busy = (m_rem > 0);
        hold = 1'b0;
        done = 1'b0;
        if (!busy && mc_start) begin
            if (mc_cycles >= 2) hold = 1'b1; else done = 1'b1;
        end else if (busy && !mc_abort) begin
            if (m_rem > 1) hold = 1'b1; else done = 1'b1;
        end
        effv = stall_req | (hold ? 6'b001000 : 6'b000000);
        h = -1;
        for (int i = 0; i < 6; i++) if (effv[i]) h = i;
        est = '0;
        if (!stall_release) for (int i = 0; i <= h; i++) est[i] = 1'b1;
        have = flush_req || m_pend;
        s = 0;
        if (flush_req) s = (int'(flush_stage) > 5) ? 5 : int'(flush_stage);
        if (m_pend && (!flush_req || m_pstage > s)) s = m_pstage;
        honour = have && (s == 5 || !est[s]);
        efl = '0;
        if (honour) for (int i = 0; i < s; i++) efl[i] = 1'b1;
        est = est & ~efl;
        kill = busy && (mc_abort || (honour && s > 3));
        if (kill) done = 1'b0;
        if (rst) begin
            est  = '0;
            efl  = '0;
            done = 1'b0;
        end
        if (chk_en) begin
            check("stall",   32'(stall),   32'(est));
            check("flush",   32'(flush),   32'(efl));
            check("mc_busy", 32'(mc_busy), 32'(busy));
            check("mc_done", 32'(mc_done), 32'(done));
`ifdef PERF_CNT_EN
            check("perf", perf_stall_cnt, m_perf);
`endif
        end
        if (rst) begin
            m_rem = 0; m_pend = 1'b0; m_pstage = 0; m_perf = '0;
        end else begin
            if (!busy && mc_start && mc_cycles >= 2) m_rem = int'(mc_cycles) - 1;
            else if (busy) m_rem = kill ? 0 : m_rem - 1;
            if (have) begin
                if (honour) m_pend = 1'b0;
                else begin m_pend = 1'b1; m_pstage = s; end
            end
`ifdef PERF_CNT_EN
            if (perf_clr) m_perf = '0;
            else if (est != '0 && m_perf != '1) m_perf = m_perf + 1;
`endif
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic drv(input logic [5:0] req, input logic rel, input logic st,
                       input logic [5:0] cyc, input logic ab, input logic fr,
                       input logic [2:0] fs);
        stall_req = req; stall_release = rel; mc_start = st; mc_cycles = cyc;
        mc_abort = ab; flush_req = fr; flush_stage = fs;
    endtask

    task automatic step(input logic [5:0] req, input logic rel, input logic st,
                        input logic [5:0] cyc, input logic ab, input logic fr,
                        input logic [2:0] fs);
        nxt();
        drv(req, rel, st, cyc, ab, fr, fs);
        settle();
    endtask

    initial begin
        rst = 1'b1;
        drv(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
`ifdef PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        nxt(); nxt();
        chk_en = 1'b1;
        settle();
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_busy",  32'(mc_busy), 32'h0);
        nxt(); rst = 1'b0;

        // Stage-4 request holds stages 0..4; release forces zero.
        step(6'b010000, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t1_stall", 32'(stall), 32'h1f);
        step(6'b010000, 1, 0, 6'd0, 0, 0, 3'd0);
        check("t1_release", 32'(stall), 32'h0);

        // Four-cycle op: three hold cycles, done on the fourth.
        step(6'd0, 0, 1, 6'd4, 0, 0, 3'd0);
        check("t2_c0", 32'(stall), 32'h0f);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t2_c1", 32'(stall), 32'h0f);
        check("t2_busy", 32'(mc_busy), 32'h1);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t2_c2", 32'(stall), 32'h0f);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t2_c3_stall", 32'(stall), 32'h0);
        check("t2_c3_done", 32'(mc_done), 32'h1);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t2_c4_busy", 32'(mc_busy), 32'h0);

        // Single-cycle op: done at once, never busy.
        step(6'd0, 0, 1, 6'd1, 0, 0, 3'd0);
        check("t3_stall", 32'(stall), 32'h0);
        check("t3_done", 32'(mc_done), 32'h1);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t3_busy", 32'(mc_busy), 32'h0);

        // Flush from held stage 3 deferred, then taken.
        step(6'b010000, 0, 0, 6'd0, 0, 1, 3'd3);
        check("t4_defer", 32'(flush), 32'h0);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t4_flush", 32'(flush), 32'h07);
        check("t4_stall", 32'(stall), 32'h0);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t4_clear", 32'(flush), 32'h0);

        // Abort with cnt=2: no hold, no done.
        step(6'd0, 0, 1, 6'd4, 0, 0, 3'd0);
        step(6'd0, 0, 0, 6'd0, 1, 0, 3'd0);
        check("t5_stall", 32'(stall), 32'h0);
        check("t5_done", 32'(mc_done), 32'h0);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("t5_idle", 32'(mc_busy), 32'h0);

        // Abort beats the final cycle (N=2).
        step(6'd0, 0, 1, 6'd2, 0, 0, 3'd0);
        step(6'd0, 0, 0, 6'd0, 1, 0, 3'd0);
        check("abort_final_done", 32'(mc_done), 32'h0);

        // Out-of-range stage clamps to the top stage, always honoured.
        step(6'b100000, 0, 0, 6'd0, 0, 1, 3'd7);
        check("clamp_flush", 32'(flush), 32'h1f);
        check("clamp_stall", 32'(stall), 32'h20);

        // Pending stage 2 merged with new stage 4 -> stage 4 wins.
        step(6'b000100, 0, 0, 6'd0, 0, 1, 3'd2);
        check("merge_defer", 32'(flush), 32'h0);
        step(6'd0, 0, 0, 6'd0, 0, 1, 3'd4);
        check("merge_flush", 32'(flush), 32'h0f);

        // Flush covering MC_STAGE kills the op.
        step(6'd0, 0, 1, 6'd8, 0, 0, 3'd0);
        step(6'd0, 0, 0, 6'd0, 0, 1, 3'd5);
        check("kill_flush", 32'(flush), 32'h1f);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("kill_idle", 32'(mc_busy), 32'h0);

        // Release hides the hold but the count still advances; restart ignored.
        step(6'd0, 1, 1, 6'd3, 0, 0, 3'd0);
        step(6'd0, 1, 1, 6'd2, 0, 0, 3'd0);
        check("rel_stall", 32'(stall), 32'h0);
        step(6'd0, 0, 0, 6'd0, 0, 0, 3'd0);
        check("rel_done", 32'(mc_done), 32'h1);

        // Reset mid-op with a pending flush: nothing survives.
        step(6'd0, 0, 1, 6'd6, 0, 0, 3'd0);
        step(6'b100000, 0, 0, 6'd0, 0, 1, 3'd4);
        check("t6_defer", 32'(flush), 32'h0);
        nxt(); rst = 1'b1; drv(6'b100000, 0, 0, 6'd0, 0, 0, 3'd0); settle();
        check("t6_rst_stall", 32'(stall), 32'h0);
        check("t6_rst_flush", 32'(flush), 32'h0);
        nxt(); rst = 1'b0; drv(6'd0, 0, 0, 6'd0, 0, 0, 3'd0); settle();
        check("t6_busy", 32'(mc_busy), 32'h0);
        check("t6_noflush", 32'(flush), 32'h0);
`ifdef PERF_CNT_EN
        check("t6_perf", perf_stall_cnt, 32'h0);
        step(6'b000001, 0, 0, 6'd0, 0, 0, 3'd0);
        step(6'b000001, 0, 0, 6'd0, 0, 0, 3'd0);
        check("perf_two", perf_stall_cnt, 32'h1);
        nxt(); perf_clr = 1'b1; settle();
        nxt(); perf_clr = 1'b0; drv(6'd0, 0, 0, 6'd0, 0, 0, 3'd0); settle();
        check("perf_clr", perf_stall_cnt, 32'h0);
`endif
        nxt(); nxt();
        settle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
